// File: rtl/reset_ce_gen.sv
// reset_ce_gen
// Front end for the RV32I pipeline on the DE2 board. It synchronises and
// debounces the raw active-low KEY button, sequences the core reset from it,
// and produces a one-cycle clock-enable tick at CLOCK_50 / 2^CE_DIV_LOG2. The
// pipeline then runs directly on CLOCK_50, gated by cpu_ce, so no divided
// ripple clock is needed.
//
// Optional feature macro: STEP_MODE_EN
//   When defined, the step_mode and key_step_n ports exist. With step_mode high
//   the free-running tick is suppressed and each debounced press of the step
//   button produces exactly one cpu_ce pulse.
//   When undefined, cpu_ce is always free-running.
module reset_ce_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int CE_DIV_LOG2     = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
`ifdef STEP_MODE_EN
    input  logic step_mode,
    input  logic key_step_n,
`endif
    output logic core_rst_n,
    output logic cpu_ce,
    output logic key_press
);

    // Counter widths are sized so that each counter can hold its terminal
    // value; every counter is cleared when it reaches that value.
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]        DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CE_DIV_LOG2-1:0] CE_LAST   = '1;

    // HOLD keeps the core in reset; RUN lets it execute.
    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Main key synchroniser and debouncer
    logic              key_meta_q;
    logic              key_s_q;
    logic              key_db_q;
    logic              key_db_d;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   db_cnt_d;

    // Reset sequencer
    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;

    // Clock-enable divider
    logic [CE_DIV_LOG2-1:0] ce_cnt_q;
    logic [CE_DIV_LOG2-1:0] ce_cnt_d;

    // Registered outputs
    logic              core_rst_n_q;
    logic              core_rst_n_d;
    logic              cpu_ce_q;
    logic              cpu_ce_d;
    logic              key_press_q;
    logic              key_press_d;

    // Tick source selection: ce_free enables the divider, step_tick requests
    // a single manual tick.
    logic              ce_free;
    logic              step_tick;

`ifdef STEP_MODE_EN
    // Step key synchroniser and debouncer
    logic              step_meta_q;
    logic              step_s_q;
    logic              step_db_q;
    logic              step_db_d;
    logic [DB_W-1:0]   step_cnt_q;
    logic [DB_W-1:0]   step_cnt_d;
    logic              step_fire;

    // Two-flop synchroniser for the raw step button, idle level is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_meta_q <= 1'b1;
            step_s_q    <= 1'b1;
        end else begin
            step_meta_q <= key_step_n;
            step_s_q    <= step_meta_q;
        end
    end

    // Step debouncer: accept a new level only after it has been stable for
    // DEBOUNCE_CYCLES cycles; any bounce back restarts the count.
    always_comb begin
        step_db_d  = step_db_q;
        step_cnt_d = '0;
        if (step_s_q != step_db_q) begin
            if (step_cnt_q == DB_LAST) begin
                step_db_d = step_s_q;
            end else begin
                step_cnt_d = step_cnt_q + DB_W'(1);
            end
        end
    end

    // Step debouncer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_db_q  <= 1'b1;
            step_cnt_q <= '0;
        end else begin
            step_db_q  <= step_db_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // A step press is the debounced 1->0 transition of the step key.
    assign step_fire = step_db_q & ~step_db_d;
    assign ce_free   = ~step_mode;
    assign step_tick = step_mode & step_fire;
`else
    assign ce_free   = 1'b1;
    assign step_tick = 1'b0;
`endif

    // Two-flop synchroniser for the raw reset key, idle level is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
        end else begin
            key_meta_q <= key_n;
            key_s_q    <= key_meta_q;
        end
    end

    // Key debouncer: count while the synchronised level differs from the
    // accepted level, and take the new level when the count reaches its end.
    always_comb begin
        key_db_d = key_db_q;
        db_cnt_d = '0;
        if (key_s_q != key_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_db_d = key_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Key debouncer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_db_q <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            key_db_q <= key_db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Reset sequencer: leave HOLD after the key has been released for
    // RST_HOLD_CYCLES cycles, drop back to HOLD on any debounced press.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_HOLD: begin
                if (!key_db_q) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                hold_cnt_d = '0;
                if (!key_db_q) begin
                    state_d = ST_HOLD;
                end
            end
        endcase
    end

    // Reset sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Output decode. All outputs follow the next state, so a press seen in
    // RUN suppresses a tick due in the same cycle, and cpu_ce can never be
    // high while core_rst_n is low. The divider only counts once the FSM has
    // been in RUN for a full cycle, which places the first tick a whole
    // period after core_rst_n rises.
    always_comb begin
        core_rst_n_d = (state_d == ST_RUN);
        key_press_d  = key_db_q & ~key_db_d;
        cpu_ce_d     = 1'b0;
        ce_cnt_d     = '0;
        if (state_d == ST_RUN) begin
            if (ce_free) begin
                cpu_ce_d = (ce_cnt_q == CE_LAST);
                if (state_q == ST_RUN) begin
                    ce_cnt_d = ce_cnt_q + CE_DIV_LOG2'(1);
                end
            end else if (step_tick) begin
                cpu_ce_d = 1'b1;
            end
        end
    end

    // Divider and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_cnt_q     <= '0;
            core_rst_n_q <= 1'b0;
            cpu_ce_q     <= 1'b0;
            key_press_q  <= 1'b0;
        end else begin
            ce_cnt_q     <= ce_cnt_d;
            core_rst_n_q <= core_rst_n_d;
            cpu_ce_q     <= cpu_ce_d;
            key_press_q  <= key_press_d;
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign cpu_ce     = cpu_ce_q;
    assign key_press  = key_press_q;

endmodule
